ram_2p_copy_engine: RTL
=======================

# ram_2p_copy_engine

Requester-side engine for the synchronous dual-port SRAM model: it drives both RAM ports to copy a block of words from one address range to another, without core involvement. Port A is used only for reads and port B only for writes, giving a sustained throughput of one word per cycle. It sits beside the data RAM and is started by a control register bank through a start/busy/done handshake.

## Interface
- Width, 32: RAM data width in bits.
- Depth, 128: RAM depth in words. Localparam Aw = $clog2(Depth).
- clk_i  in  1  single clock; both RAM port clocks are tied to it.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only when busy_o=0.
- src_addr_i  in  Aw  first source word address.
- dst_addr_i  in  Aw  first destination word address.
- len_i  in  Aw+1  word count, 0..Depth.
- abort_i  in  1  cancels an active copy.
- busy_o  out  1  copy in progress.
- done_o  out  1  one-cycle completion pulse.
- a_req_o, a_write_o  out  1 each  port A request; a_write_o is constant 0.
- a_addr_o  out  Aw  port A address.
- a_wdata_o, a_wmask_o  out  Width each  constant 0.
- a_rdata_i  in  Width  port A read data, valid the cycle after a read request.
- b_req_o, b_write_o  out  1 each  port B request; b_write_o=1 whenever b_req_o=1.
- b_addr_o  out  Aw  port B address.
- b_wdata_o  out  Width  write data.
- b_wmask_o  out  Width  all ones.
- b_rdata_i  in  Width  unused.

## Operation
- FSM states:
  - IDLE: accepts start_i.
  - RUN: issues reads, with the write pipelined one cycle behind.
  - DRAIN: issues the final write with no read.
- IDLE transitions:
  - start_i with len_i≠0 latches src_addr_i, dst_addr_i and len_i, then goes to RUN.
  - start_i with len_i=0 pulses done_o in the next cycle with no RAM access, and stays in IDLE.
- RUN, per cycle:
  - Drive a_req_o=1 with a_addr_o = src + rd_cnt.
  - If a read was issued in the previous cycle, drive b_req_o=1 with b_addr_o = dst + wr_cnt and b_wdata_o = a_rdata_i.
  - When the last read (rd_cnt = len−1) has been issued, go to DRAIN.
- DRAIN: issue the final write, then go to IDLE and register done_o=1 for the following cycle.
- Addresses are computed modulo Depth; src+k and dst+k wrap from Depth−1 to 0.
- Counters are Aw+1 bits wide, so len=Depth is legal.
- start_i while busy_o=1 is ignored. No queuing.
- abort_i while busy_o=1 has the following effect:
  - a_req_o and b_req_o are 0 from the next cycle.
  - FSM returns to IDLE and done_o is not pulsed.
  - A read still outstanding at abort is discarded.
- abort_i while idle has no effect.
- If start_i and abort_i are sampled together in IDLE, the start is accepted.
- Overlap handling:
  - Non-overlapping ranges are copied exactly.
  - Overlapping ranges with dst = src or dst = src+1 (mod Depth) are copied exactly, because the RAM reads the old value on a same-edge read/write.
  - For dst−src (mod Depth) in 2..len−1, destination contents are undefined. This case is not detected.
- Reset values: FSM=IDLE, busy_o=0, done_o=0, a_req_o=0, b_req_o=0, all addresses 0, b_wdata_o=0.
- Mid-operation reset returns to IDLE immediately. The partially written range is left as is.

## Timing
- Let cycle 0 be the cycle in which start_i is sampled high in IDLE with len=L>0.
- a_req_o is high in cycles 1..L.
- b_req_o is high in cycles 2..L+1.
- busy_o is high in cycles 1..L+1.
- done_o is high in cycle L+2, with busy_o=0. A new start_i is accepted in that same cycle.
- Total latency from start to done is L+2 cycles.
- Throughput is 1 word/cycle with no bubbles.
- For len=0, done_o is high in cycle 1 and busy_o never rises.
- All outputs are registered. There are no combinational paths from inputs to outputs, except b_wdata_o = a_rdata_i during a write cycle.

## Configuration
- RAM_COPY_FILL_EN defined:
  - Adds ports fill_i (in, 1) and fill_data_i (in, Width), both latched at start.
  - With fill_i=1, port A stays idle.
  - Writes of fill_data to dst..dst+L−1 occur in cycles 1..L.
  - busy_o is high in cycles 1..L and done_o in cycle L+1.
  - The FSM goes directly to DRAIN-equivalent completion, with no pipeline stage.
- RAM_COPY_FILL_EN undefined: these ports are absent, and only the copy behaviour exists.

## Test plan
- Reset, then preload mem[0..3] = 0x11,0x22,0x33,0x44. Start with src=0, dst=64, len=4 → mem[64..67] = 0x11..0x44, and done_o is high in cycle 6.
- Start with src=126, dst=10, len=4 (Depth=128) → reads occur at 126,127,0,1 and mem[10..13] receives those values.
- Preload 0..7 with 0xA0+i. Start with src=0, dst=1, len=7 → mem[1..7] = 0xA0..0xA6.
- Start with len=0 → done_o pulses in cycle 1, with no a_req_o or b_req_o ever high.
- Start with len=8 and assert abort_i in cycle 3 → at most 2 writes occur, no done_o, busy_o=0 in cycle 4, and a restart in that cycle is accepted.
- With RAM_COPY_FILL_EN: fill_i=1, fill_data=0xDEADBEEF, dst=20, len=3 → mem[20..22] = 0xDEADBEEF, a_req_o never high, and done_o in cycle 4.

Source files
------------

// File: rtl/ram_2p_copy_engine_if.sv
// ram_2p_copy_engine_if: dual-port SRAM request bundle between the copy engine (master) and the RAM (slave).
interface ram_2p_copy_engine_if #(
    parameter int Width = 32,
    parameter int Depth = 128
);
    localparam int Aw = $clog2(Depth);
    logic             a_req_o;
    logic             a_write_o;
    logic [Aw-1:0]    a_addr_o;
    logic [Width-1:0] a_wdata_o;
    logic [Width-1:0] a_wmask_o;
    logic [Width-1:0] a_rdata_i;
    logic             b_req_o;
    logic             b_write_o;
    logic [Aw-1:0]    b_addr_o;
    logic [Width-1:0] b_wdata_o;
    logic [Width-1:0] b_wmask_o;
    logic [Width-1:0] b_rdata_i;
    modport master (
        output a_req_o, a_write_o, a_addr_o, a_wdata_o, a_wmask_o,
        input  a_rdata_i,
        output b_req_o, b_write_o, b_addr_o, b_wdata_o, b_wmask_o,
        input  b_rdata_i
    );
    modport slave (
        input  a_req_o, a_write_o, a_addr_o, a_wdata_o, a_wmask_o,
        output a_rdata_i,
        input  b_req_o, b_write_o, b_addr_o, b_wdata_o, b_wmask_o,
        output b_rdata_i
    );
endinterface

// File: rtl/ram_2p_copy_engine.sv
// ram_2p_copy_engine: block copy through a dual-port SRAM, reading on port A and writing on port B one cycle behind.
// Define RAM_COPY_FILL_EN to add a fill mode that writes a constant word without reading.
module ram_2p_copy_engine #(
    parameter int  Width = 32,
    parameter int  Depth = 128,
    localparam int Aw    = $clog2(Depth)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [Aw-1:0]         src_addr_i,
    input  logic [Aw-1:0]         dst_addr_i,
    input  logic [Aw:0]           len_i,
    input  logic                  abort_i,
`ifdef RAM_COPY_FILL_EN
    input  logic                  fill_i,
    input  logic [Width-1:0]      fill_data_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    ram_2p_copy_engine_if.master  ram
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t           state_q, state_d;
    logic [Aw-1:0]    src_q, src_d, dst_q, dst_d, a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [Aw:0]      len_q, len_d, rd_q, rd_d, wr_q, wr_d;
    logic             a_req_q, a_req_d, b_req_q, b_req_d, busy_d, done_d;
    logic             fill_in, fill_q;
    logic [Width-1:0] fdata_q;
`ifdef RAM_COPY_FILL_EN
    assign fill_in = fill_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_q  <= 1'b0;
            fdata_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            fill_q  <= fill_i;
            fdata_q <= fill_data_i;
        end
    end
`else
    assign fill_in = 1'b0;
    assign fill_q  = 1'b0;
    assign fdata_q = '0;
`endif
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        a_req_d  = 1'b0;
        a_addr_d = a_addr_q;
        b_req_d  = 1'b0;
        b_addr_d = b_addr_q;
        busy_d   = busy_o;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && len_i == '0) begin
                    done_d = 1'b1;
                end else if (start_i) begin
                    state_d  = RUN;
                    src_d    = src_addr_i;
                    dst_d    = dst_addr_i;
                    len_d    = len_i;
                    busy_d   = 1'b1;
                    rd_d     = 1;
                    wr_d     = fill_in ? 1 : 0;
                    a_req_d  = !fill_in;
                    a_addr_d = src_addr_i;
                    b_req_d  = fill_in;
                    b_addr_d = dst_addr_i;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (fill_q) begin
                    // fill has no read stage, so completion follows the last write directly
                    b_req_d  = wr_q != len_q;
                    b_addr_d = dst_q + wr_q[Aw-1:0];
                    wr_d     = wr_q + 1;
                    state_d  = wr_q == len_q ? IDLE : RUN;
                    busy_d   = wr_q != len_q;
                    done_d   = wr_q == len_q;
                end else begin
                    a_req_d  = rd_q != len_q;
                    a_addr_d = src_q + rd_q[Aw-1:0];
                    rd_d     = rd_q + 1;
                    b_req_d  = 1'b1;
                    b_addr_d = dst_q + wr_q[Aw-1:0];
                    wr_d     = wr_q + 1;
                    state_d  = rd_q == len_q ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = !abort_i;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            a_req_q  <= 1'b0;
            a_addr_q <= '0;
            b_req_q  <= 1'b0;
            b_addr_q <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            a_req_q  <= a_req_d;
            a_addr_q <= a_addr_d;
            b_req_q  <= b_req_d;
            b_addr_q <= b_addr_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end
    assign ram.a_req_o   = a_req_q;
    assign ram.a_write_o = 1'b0;
    assign ram.a_addr_o  = a_addr_q;
    assign ram.a_wdata_o = '0;
    assign ram.a_wmask_o = '0;
    assign ram.b_req_o   = b_req_q;
    assign ram.b_write_o = b_req_q;
    assign ram.b_addr_o  = b_addr_q;
    // read data lands the cycle after the read, exactly when its write is issued
    assign ram.b_wdata_o = !b_req_q ? '0 : fill_q ? fdata_q : ram.a_rdata_i;
    assign ram.b_wmask_o = '1;
endmodule
